// File: rtl/ahb2apb_bridge_ctrl.sv
// AHB-Lite slave to APB3 master bridge: one-hot slave decode, PREADY wait states,
// PSLVERR -> two-cycle AHB ERROR, pipelined back-to-back transfers. Define AHB2APB_TIMEOUT_EN for the ACCESS timeout.
module ahb2apb_bridge_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SHIFT   = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL_i,
  input  logic [ADDR_W-1:0]   HADDR_i,
  input  logic [1:0]          HTRANS_i,
  input  logic                HWRITE_i,
  input  logic [DATA_W-1:0]   HWDATA_i,
  input  logic                HREADY_i,
  output logic                HREADYOUT_o,
  output logic                HRESP_o,
  output logic [DATA_W-1:0]   HRDATA_o,
  output logic [ADDR_W-1:0]   PADDR_o,
  output logic [NUM_SLV-1:0]  PSEL_o,
  output logic                PENABLE_o,
  output logic                PWRITE_o,
  output logic [DATA_W-1:0]   PWDATA_o,
  input  logic [DATA_W-1:0]   PRDATA_i,
  input  logic                PREADY_i,
  input  logic                PSLVERR_i
);
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WWAIT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  paddr_q;
  logic [NUM_SLV-1:0] psel_q, psel_d, dec_sel;
  logic               penable_q, pwrite_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [IDX_W-1:0]   sel_idx;
  logic               valid, accept, acc_ok, acc_err, timeout;

  assign valid   = HSEL_i & HREADY_i & HTRANS_i[1];
  assign acc_ok  = (state_q == S_ACCESS) & PREADY_i & ~PSLVERR_i;
  assign acc_err = ((state_q == S_ACCESS) & PREADY_i & PSLVERR_i) | timeout;
  // New transfers are taken only where the AHB side is ready: IDLE, ERR2 or an OKAY completion.
  assign accept  = valid & ((state_q == S_IDLE) | (state_q == S_ERR2) | acc_ok);

  // Read SETUP follows the address phase directly, so decode the live HADDR when accepting.
  assign sel_idx = accept ? HADDR_i[SLV_SHIFT +: IDX_W] : paddr_q[SLV_SHIFT +: IDX_W];

  if (NUM_SLV == 1) begin : g_one
    logic unused_idx;
    assign unused_idx = ^sel_idx;
    assign dec_sel    = 1'b1;
  end else begin : g_dec
    always_comb begin
      dec_sel          = '0;
      dec_sel[sel_idx] = 1'b1;
    end
  end

`ifdef AHB2APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == S_ACCESS) & ~PREADY_i & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == S_ACCESS) && !PREADY_i && !timeout) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_to;
  assign unused_to = 32'(TIMEOUT_CYC);
  assign timeout   = 1'b0;
`endif

  logic unused_htrans;
  assign unused_htrans = HTRANS_i[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: state_d = S_IDLE;
      S_WWAIT:        state_d = S_SETUP;
      S_SETUP:        state_d = S_ACCESS;
      S_ACCESS: begin
        if (acc_err)     state_d = S_ERR1;
        else if (acc_ok) state_d = S_IDLE;
      end
      S_ERR1:         state_d = S_ERR2;
      default:        state_d = S_IDLE;
    endcase
    if (accept) state_d = HWRITE_i ? S_WWAIT : S_SETUP;
  end

  assign psel_d = ((state_d == S_SETUP) || (state_d == S_ACCESS)) ? dec_sel : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= (state_d == S_ACCESS);
      if (accept) begin
        paddr_q  <= HADDR_i;
        pwrite_q <= HWRITE_i;
      end
      if (state_q == S_WWAIT) pwdata_q <= HWDATA_i;
    end
  end

  assign HREADYOUT_o = (state_q == S_IDLE) | (state_q == S_ERR2) | acc_ok;
  assign HRESP_o     = (state_q == S_ERR1) | (state_q == S_ERR2);
  assign HRDATA_o    = (acc_ok & ~pwrite_q) ? PRDATA_i : '0;
  assign PADDR_o     = paddr_q;
  assign PSEL_o      = psel_q;
  assign PENABLE_o   = penable_q;
  assign PWRITE_o    = pwrite_q;
  assign PWDATA_o    = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_bridge_ctrl.sv
// Randomised transaction-level bench for ahb2apb_bridge_ctrl; expected cycle timing derived
// from per-transfer latency arithmetic, APB slave backed by an associative memory.
module tb_ahb2apb_bridge_ctrl;
  localparam int TO_CYC = 16;

  logic        HCLK, HRESETn;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
  logic [3:0]  PSEL;

  ahb2apb_bridge_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_SHIFT(12), .TIMEOUT_CYC(TO_CYC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_i(HSEL), .HADDR_i(HADDR), .HTRANS_i(HTRANS),
    .HWRITE_i(HWRITE), .HWDATA_i(HWDATA), .HREADY_i(HREADY), .HREADYOUT_o(HREADYOUT),
    .HRESP_o(HRESP), .HRDATA_o(HRDATA), .PADDR_o(PADDR), .PSEL_o(PSEL), .PENABLE_o(PENABLE),
    .PWRITE_o(PWRITE), .PWDATA_o(PWDATA), .PRDATA_i(PRDATA), .PREADY_i(PREADY), .PSLVERR_i(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_addr, last_wdata;
  logic        last_wr;
  int          nvec = 0;
  int          nerr = 0;

  function automatic txn_t mk(bit wr, logic [31:0] a, logic [31:0] d, int w, bit e);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d; t.waits = w; t.err = e;
    return t;
  endfunction

  function automatic logic [31:0] rd_val(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_C3C3);
  endfunction

  function automatic logic [3:0] sel_of(logic [31:0] a);
    return 4'(32'd1 << ((a >> 12) % 4));
  endfunction

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
  endtask

  // Issues every queued transfer; each cycle compares all outputs against the timing implied
  // by: data phase lasts (write ? 2 : 1) + waits cycles, plus two ERROR cycles on a slave error.
  task automatic run_q(input bit gaps);
    txn_t dp, ap;
    bit act, pres, exp_rdy, in_acc, in_sel, exp_resp;
    int dc, L, E, budget, k;
    logic [31:0] rv, exp_rdata;
    logic [3:0]  exp_psel;
    act = 0; dc = 0; budget = 0;
    while ((q.size() > 0 || act) && budget < 3000) begin
      budget++;
      @(posedge HCLK); #1;
      L = 0; E = 0;
      if (act) begin
        L = (dp.wr ? 2 : 1) + dp.waits;
        E = dp.err ? L + 2 : L;
      end
      exp_rdy   = !act || (dc == E);
      in_acc    = act && dc >= L - dp.waits && dc <= L;
      in_sel    = act && dc >= L - dp.waits - 1 && dc <= L;
      exp_resp  = act && dp.err && dc > L;
      rv        = act ? rd_val(dp.addr) : 32'h0;
      exp_rdata = (act && !dp.wr && !dp.err && dc == L) ? rv : 32'h0;
      exp_psel  = in_sel ? sel_of(dp.addr) : 4'h0;

      pres = q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
      k    = $urandom_range(0, 2);
      if (pres) begin
        ap = q[0];
        HSEL = 1'b1; HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11;
        HADDR = ap.addr; HWRITE = ap.wr;
      end else begin
        if (k == 2 && act && exp_rdy) k = 0;
        HADDR = $urandom; HWRITE = 1'($urandom);
        case (k)
          0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
          1:       begin HSEL = 1'b1; HTRANS = {1'b0, 1'($urandom)}; end
          default: begin HSEL = 1'b1; HTRANS = 2'b10; end
        endcase
      end
      HREADY  = act ? exp_rdy : ((!pres && k == 2) ? 1'b0 : 1'b1);
      HWDATA  = (act && dp.wr) ? dp.wdata : $urandom;
      PREADY  = in_acc ? (dc == L) : 1'($urandom);
      PSLVERR = (in_acc && dc == L) ? dp.err : 1'($urandom);
      PRDATA  = (in_acc && dc == L) ? rv : $urandom;
      #2;

      nvec++; if (HREADYOUT !== exp_rdy)
        begin nerr++; $display("FAIL hreadyout t=%0t got %b exp %b", $time, HREADYOUT, exp_rdy); end
      nvec++; if (HRESP !== exp_resp)
        begin nerr++; $display("FAIL hresp t=%0t got %b exp %b", $time, HRESP, exp_resp); end
      nvec++; if (HRDATA !== exp_rdata)
        begin nerr++; $display("FAIL hrdata t=%0t got %h exp %h", $time, HRDATA, exp_rdata); end
      nvec++; if (PSEL !== exp_psel)
        begin nerr++; $display("FAIL psel t=%0t got %b exp %b", $time, PSEL, exp_psel); end
      nvec++; if (PENABLE !== in_acc)
        begin nerr++; $display("FAIL penable t=%0t got %b exp %b", $time, PENABLE, in_acc); end
      if (in_sel) begin
        nvec++; if (PADDR !== dp.addr || PWRITE !== dp.wr)
          begin nerr++; $display("FAIL paddr_pwrite t=%0t got %h/%b exp %h/%b", $time, PADDR, PWRITE, dp.addr, dp.wr); end
      end
      if (in_acc && dp.wr) begin
        nvec++; if (PWDATA !== dp.wdata)
          begin nerr++; $display("FAIL pwdata t=%0t got %h exp %h", $time, PWDATA, dp.wdata); end
      end
      if (!act) begin
        nvec++; if (PADDR !== last_addr || PWRITE !== last_wr || PWDATA !== last_wdata)
          begin nerr++; $display("FAIL apb_hold t=%0t got %h/%b/%h exp %h/%b/%h", $time, PADDR, PWRITE, PWDATA, last_addr, last_wr, last_wdata); end
      end

      if (act) begin
        if (dc == E) begin
          if (dp.wr && !dp.err) mem[dp.addr] = dp.wdata;
          last_addr = dp.addr; last_wr = dp.wr;
          if (dp.wr) last_wdata = dp.wdata;
          act = 0;
        end else dc++;
      end
      if (pres && HREADY) begin
        dp = q.pop_front(); act = 1; dc = 0;
      end
    end
    if (q.size() > 0 || act) begin
      nerr++; $display("FAIL run_q_budget t=%0t pending %0d exp 0", $time, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    drive_idle(); HRESETn = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    nvec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
      begin nerr++; $display("FAIL reset_hresp t=%0t got %b/%b exp 1/0", $time, HREADYOUT, HRESP); end
    nvec++; if (PSEL !== 4'h0 || PENABLE !== 1'b0 || PWRITE !== 1'b0)
      begin nerr++; $display("FAIL reset_apb_ctl t=%0t got %b/%b/%b exp 0", $time, PSEL, PENABLE, PWRITE); end
    nvec++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || HRDATA !== 32'h0)
      begin nerr++; $display("FAIL reset_data t=%0t got %h/%h/%h exp 0", $time, PADDR, PWDATA, HRDATA); end
    repeat (2) @(posedge HCLK);
    #1;
    nvec++; if (HREADYOUT !== 1'b1 || PSEL !== 4'h0 || PENABLE !== 1'b0)
      begin nerr++; $display("FAIL reset_held t=%0t got %b/%b/%b exp 1/0/0", $time, HREADYOUT, PSEL, PENABLE); end
    HRESETn = 1'b1;
    last_addr = '0; last_wr = 1'b0; last_wdata = '0;
  endtask

  task automatic test_write();
    q.push_back(mk(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 0, 1'b0));
    run_q(1'b0);
  endtask

  task automatic test_read_wait();
    mem[32'h0000_1004] = 32'h1234_5678;
    q.push_back(mk(1'b0, 32'h0000_1004, 32'h0, 2, 1'b0));
    run_q(1'b0);
  endtask

  task automatic test_error();
    q.push_back(mk(1'b0, 32'h0000_2008, 32'h0, 0, 1'b1));
    q.push_back(mk(1'b1, 32'h0000_3004, 32'hCAFE_0001, 0, 1'b0));
    q.push_back(mk(1'b1, 32'h0000_1008, 32'hCAFE_0002, 1, 1'b1));
    q.push_back(mk(1'b0, 32'h0000_3004, 32'h0, 0, 1'b0));
    run_q(1'b0);
  endtask

  task automatic test_back_to_back();
    q.push_back(mk(1'b1, 32'h0000_3000, 32'hA5A5_0F0F, 0, 1'b0));
    q.push_back(mk(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0));
    q.push_back(mk(1'b0, 32'h0000_3000, 32'h0, 0, 1'b0));
    q.push_back(mk(1'b1, 32'h0000_1000, 32'h0BAD_F00D, 1, 1'b0));
    run_q(1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      a = (($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_0000) : 32'h0)
        | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2);
      q.push_back(mk(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 5) == 0));
    end
    run_q(1'b1);
  endtask

`ifndef AHB2APB_TIMEOUT_EN
  task automatic test_long_wait();
    q.push_back(mk(1'b0, 32'h0000_2004, 32'h0, 20, 1'b0));
    run_q(1'b0);
  endtask
`endif

  task automatic test_reset_mid_access();
    @(posedge HCLK); #1;
    drive_idle();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1008;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b0;
    @(posedge HCLK); #1;
    nvec++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010)
      begin nerr++; $display("FAIL mid_access_pre t=%0t got %b/%b exp 1/0010", $time, PENABLE, PSEL); end
    HRESETn = 1'b0;
    #1;
    nvec++; if (PSEL !== 4'h0 || PENABLE !== 1'b0 || HREADYOUT !== 1'b1)
      begin nerr++; $display("FAIL mid_access_reset t=%0t got %b/%b/%b exp 0/0/1", $time, PSEL, PENABLE, HREADYOUT); end
    nvec++; if (PADDR !== 32'h0 || HRESP !== 1'b0)
      begin nerr++; $display("FAIL mid_access_regs t=%0t got %h/%b exp 0/0", $time, PADDR, HRESP); end
    #4 HRESETn = 1'b1;
    HREADY = 1'b1;
    last_addr = '0; last_wr = 1'b0; last_wdata = '0;
  endtask

`ifdef AHB2APB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    @(posedge HCLK); #1;
    drive_idle();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_3008;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge HCLK); #1;
      if (PENABLE === 1'b1) n++;
      else break;
    end
    nvec++; if (n != TO_CYC)
      begin nerr++; $display("FAIL timeout_len got %0d exp %0d", n, TO_CYC); end
    nvec++; if (PSEL !== 4'h0 || HRESP !== 1'b1 || HREADYOUT !== 1'b0)
      begin nerr++; $display("FAIL timeout_err1 t=%0t got %b/%b/%b exp 0/1/0", $time, PSEL, HRESP, HREADYOUT); end
    HREADY = 1'b1;
    @(posedge HCLK); #1;
    nvec++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b1)
      begin nerr++; $display("FAIL timeout_err2 t=%0t got %b/%b exp 1/1", $time, HRESP, HREADYOUT); end
    @(posedge HCLK); #1;
    nvec++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1)
      begin nerr++; $display("FAIL timeout_idle t=%0t got %b/%b exp 0/1", $time, HRESP, HREADYOUT); end
    last_addr = 32'h0000_3008; last_wr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_back_to_back();
    test_random();
`ifndef AHB2APB_TIMEOUT_EN
    test_long_wait();
`endif
    test_reset_mid_access();
`ifdef AHB2APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
